// File: rtl/ocp_sram_slave.sv
// ocp_sram_slave: OCP slave target backed by a register-array memory.
// Handles one transaction at a time: single or INCR bursts of reads (RD),
// posted writes (WR) and non-posted writes (WRNP). Any other command, or a
// burst sequence other than INCR, is answered with an ERR response.
// Optional feature macro: OCP_SRAM_BYTEEN_EN (byte-enabled writes).
//
// Handshakes: a request is taken on a cycle where m_cmd != IDLE and
// s_cmd_accept = 1; a write beat is taken where m_data_valid = 1 and
// s_data_accept = 1; a response beat completes where s_resp != NULL and
// m_resp_accept = 1, and the response outputs stay stable until then.
// The FSM state is visible as r_state for external checkers.
module ocp_sram_slave #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int BLEN_WIDTH = 4,
    parameter int TAGI_WIDTH = 5
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [2:0]              m_cmd,
    input  logic [ADDR_WIDTH-1:0]   m_addr,
    input  logic [BLEN_WIDTH-1:0]   m_burst_length,
    input  logic [2:0]              m_burst_seq,
    input  logic [TAGI_WIDTH-1:0]   m_tagid,
    input  logic [DATA_WIDTH-1:0]   m_data,
    input  logic [DATA_WIDTH/8-1:0] m_data_byteen,
    input  logic                    m_data_valid,
    input  logic                    m_data_last,
    input  logic                    m_resp_accept,
    output logic                    s_cmd_accept,
    output logic                    s_data_accept,
    output logic [1:0]              s_resp,
    output logic [DATA_WIDTH-1:0]   s_data,
    output logic                    s_resp_last,
    output logic [TAGI_WIDTH-1:0]   s_tagid
);

    // OCP command, burst sequence and response encodings
    localparam logic [2:0] CMD_IDLE = 3'd0;
    localparam logic [2:0] CMD_WR   = 3'd1;
    localparam logic [2:0] CMD_RD   = 3'd2;
    localparam logic [2:0] CMD_WRNP = 3'd5;
    localparam logic [2:0] SEQ_INCR = 3'd0;
    localparam logic [1:0] RESP_NULL = 2'd0;
    localparam logic [1:0] RESP_DVA  = 2'd1;
    localparam logic [1:0] RESP_ERR  = 2'd3;

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [BLEN_WIDTH-1:0] LEN_ONE  = BLEN_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WDATA = 2'd1,
        ST_RDATA = 2'd2,
        ST_WRESP = 2'd3
    } state_t;

    state_t                  r_state;
    state_t                  w_next_state;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [BLEN_WIDTH-1:0]   r_len;
    logic [BLEN_WIDTH-1:0]   r_cnt;
    logic [TAGI_WIDTH-1:0]   r_tag;
    logic [2:0]              r_cmd;
    logic                    r_err;      // transaction will be answered with ERR
    logic                    r_req_err;  // request itself was bad: suppress memory writes
    logic [DATA_WIDTH-1:0]   r_mem [DEPTH];

    logic w_req;
    logic w_cmd_write;
    logic w_cmd_read;
    logic w_last_beat;
    logic w_wbeat;
    logic w_mem_we;

    assign w_req       = (r_state == ST_IDLE) && (m_cmd != CMD_IDLE) && !rst;
    assign w_cmd_write = (m_cmd == CMD_WR) || (m_cmd == CMD_WRNP);
    assign w_cmd_read  = (m_cmd == CMD_RD);
    assign w_last_beat = (r_cnt == (r_len - LEN_ONE));
    assign w_wbeat     = (r_state == ST_WDATA) && m_data_valid;
    // A bad request still consumes its data beats but never touches memory;
    // a misplaced m_data_last only flags the response, the beats are written.
    assign w_mem_we    = w_wbeat && !r_req_err && !rst;

    // Next-state and response outputs; everything defaults to the idle values
    always_comb begin
        w_next_state  = r_state;
        s_cmd_accept  = 1'b0;
        s_data_accept = 1'b0;
        s_resp        = RESP_NULL;
        s_data        = '0;
        s_resp_last   = 1'b0;
        s_tagid       = '0;
        case (r_state)
            ST_IDLE: begin
                s_cmd_accept = !rst;
                if (m_cmd != CMD_IDLE) begin
                    w_next_state = w_cmd_write ? ST_WDATA : ST_RDATA;
                end
            end
            ST_WDATA: begin
                s_data_accept = 1'b1;
                if (m_data_valid && w_last_beat) begin
                    w_next_state = (r_cmd == CMD_WRNP) ? ST_WRESP : ST_IDLE;
                end
            end
            ST_RDATA: begin
                s_resp      = r_err ? RESP_ERR : RESP_DVA;
                s_data      = r_err ? '0 : r_mem[r_addr];
                s_tagid     = r_tag;
                s_resp_last = w_last_beat || r_err;
                if (m_resp_accept && (w_last_beat || r_err)) begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_WRESP: begin
                s_resp      = r_err ? RESP_ERR : RESP_DVA;
                s_resp_last = 1'b1;
                s_tagid     = r_tag;
                if (m_resp_accept) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // State register plus request latching and beat address/count tracking
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_addr    <= '0;
            r_len     <= LEN_ONE;
            r_cnt     <= '0;
            r_tag     <= '0;
            r_cmd     <= CMD_IDLE;
            r_err     <= 1'b0;
            r_req_err <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_req) begin
                r_addr <= m_addr;
                r_tag  <= m_tagid;
                r_cmd  <= m_cmd;
                r_cnt  <= '0;
                if (w_cmd_write || w_cmd_read) begin
                    r_len     <= (m_burst_length == '0) ? LEN_ONE : m_burst_length;
                    r_err     <= (m_burst_seq != SEQ_INCR);
                    r_req_err <= (m_burst_seq != SEQ_INCR);
                end else begin
                    // Unsupported command: single ERR read beat
                    r_len     <= LEN_ONE;
                    r_err     <= 1'b1;
                    r_req_err <= 1'b1;
                end
            end else if (w_wbeat) begin
                r_addr <= r_addr + ADDR_ONE;
                r_cnt  <= r_cnt + LEN_ONE;
                if (m_data_last != w_last_beat) begin
                    r_err <= 1'b1;
                end
            end else if ((r_state == ST_RDATA) && m_resp_accept) begin
                r_addr <= r_addr + ADDR_ONE;
                r_cnt  <= r_cnt + LEN_ONE;
            end
        end
    end

`ifdef OCP_SRAM_BYTEEN_EN
    // Byte-masked memory write; lanes with byteen=0 keep their old contents
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            for (int i = 0; i < DATA_WIDTH / 8; i++) begin
                if (m_data_byteen[i]) begin
                    r_mem[r_addr][i*8 +: 8] <= m_data[i*8 +: 8];
                end
            end
        end
    end
`else
    logic w_unused_byteen;
    assign w_unused_byteen = ^m_data_byteen;

    // Full-word memory write; byte enables have no effect in this build
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[r_addr] <= m_data;
        end
    end
`endif

endmodule

// File: tb/tb_ocp_sram_slave.sv
// tb_ocp_sram_slave: directed scenarios for ocp_sram_slave. Expected response
// beats are pushed to exp_q when a request is issued and popped as the DUT
// presents each beat. Inputs change 1 time unit after the rising edge;
// outputs are sampled at that same point, before inputs are updated.
module tb_ocp_sram_slave;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int BW = 4;
  localparam int TW = 5;
  localparam int EW = 2 + 1 + TW + DW;

  localparam logic [2:0] CMD_IDLE = 3'd0;
  localparam logic [2:0] CMD_WR   = 3'd1;
  localparam logic [2:0] CMD_RD   = 3'd2;
  localparam logic [2:0] CMD_RDEX = 3'd3;
  localparam logic [2:0] CMD_WRNP = 3'd5;
  localparam logic [2:0] SEQ_INCR = 3'd0;
  localparam logic [2:0] SEQ_WRAP = 3'd2;
  localparam logic [1:0] RESP_NULL = 2'd0;
  localparam logic [1:0] RESP_DVA  = 2'd1;
  localparam logic [1:0] RESP_ERR  = 2'd3;

  logic              clk;
  logic              rst;
  logic [2:0]        m_cmd;
  logic [AW-1:0]     m_addr;
  logic [BW-1:0]     m_burst_length;
  logic [2:0]        m_burst_seq;
  logic [TW-1:0]     m_tagid;
  logic [DW-1:0]     m_data;
  logic [DW/8-1:0]   m_data_byteen;
  logic              m_data_valid;
  logic              m_data_last;
  logic              m_resp_accept;
  logic              s_cmd_accept;
  logic              s_data_accept;
  logic [1:0]        s_resp;
  logic [DW-1:0]     s_data;
  logic              s_resp_last;
  logic [TW-1:0]     s_tagid;

  logic [EW-1:0]     obs;
  logic [EW-1:0]     exp_q[$];
  int                checks = 0;
  int                errors = 0;

  assign obs = {s_resp, s_resp_last, s_tagid, s_data};

  ocp_sram_slave #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .BLEN_WIDTH(BW),
    .TAGI_WIDTH(TW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .m_cmd         (m_cmd),
    .m_addr        (m_addr),
    .m_burst_length(m_burst_length),
    .m_burst_seq   (m_burst_seq),
    .m_tagid       (m_tagid),
    .m_data        (m_data),
    .m_data_byteen (m_data_byteen),
    .m_data_valid  (m_data_valid),
    .m_data_last   (m_data_last),
    .m_resp_accept (m_resp_accept),
    .s_cmd_accept  (s_cmd_accept),
    .s_data_accept (s_data_accept),
    .s_resp        (s_resp),
    .s_data        (s_data),
    .s_resp_last   (s_resp_last),
    .s_tagid       (s_tagid)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [EW-1:0] pack_resp(input logic [1:0] r, input logic l,
                                              input logic [TW-1:0] t, input logic [DW-1:0] d);
    return {r, l, t, d};
  endfunction

  // driver: issue one request and wait (bounded) for it to be accepted
  task automatic send_req(input logic [2:0] cmd, input logic [AW-1:0] addr,
                          input logic [BW-1:0] blen, input logic [2:0] seq,
                          input logic [TW-1:0] tag);
    int n;
    m_cmd = cmd;
    m_addr = addr;
    m_burst_length = blen;
    m_burst_seq = seq;
    m_tagid = tag;
    n = 0;
    while (s_cmd_accept !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) begin
      checks++;
      errors++;
      $display("FAIL cmd_accept_timeout got s_cmd_accept=%b required 1", s_cmd_accept);
    end
    @(posedge clk); #1;
    m_cmd = CMD_IDLE;
  endtask

  // driver: present one write data beat and wait (bounded) for acceptance
  task automatic send_beat(input logic [DW-1:0] data, input logic [DW/8-1:0] be,
                           input logic last);
    int n;
    m_data = data;
    m_data_byteen = be;
    m_data_last = last;
    m_data_valid = 1'b1;
    n = 0;
    while (s_data_accept !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) begin
      checks++;
      errors++;
      $display("FAIL data_accept_timeout got s_data_accept=%b required 1", s_data_accept);
    end
    @(posedge clk); #1;
    m_data_valid = 1'b0;
    m_data_last = 1'b0;
  endtask

  // scoreboard: wait for a response beat, compare it with the queue head;
  // with hold=1 the beat is stalled two cycles and must stay unchanged
  task automatic sb_collect(input bit hold, input string name);
    int n;
    logic [EW-1:0] exp;
    m_resp_accept = 1'b0;
    n = 0;
    while (s_resp === RESP_NULL && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (n >= 50 || exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s no_response got resp=%0d required a queued beat (queue size %0d)",
               name, s_resp, exp_q.size());
      if (exp_q.size() != 0) void'(exp_q.pop_front());
      return;
    end
    exp = exp_q.pop_front();
    if (hold) begin
      if (obs !== exp) begin
        errors++;
        $display("FAIL %s_stall0 got %h required %h", name, obs, exp);
      end
      @(posedge clk); #1;
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL %s_stall1 got %h required %h", name, obs, exp);
      end
      checks++;
    end
    m_resp_accept = 1'b1;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got resp=%0d last=%0b tag=%0d data=%h required resp=%0d last=%0b tag=%0d data=%h",
               name, s_resp, s_resp_last, s_tagid, s_data,
               exp[EW-1 -: 2], exp[EW-3], exp[DW +: TW], exp[DW-1:0]);
    end
    @(posedge clk); #1;
    m_resp_accept = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++;
    if (s_cmd_accept !== 1'b0) begin
      errors++;
      $display("FAIL reset_cmd_accept got %b required 0", s_cmd_accept);
    end
    checks++;
    if ({s_resp, s_data, s_resp_last, s_tagid, s_data_accept} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got resp=%0d data=%h last=%b tag=%0d daccept=%b required all 0",
               s_resp, s_data, s_resp_last, s_tagid, s_data_accept);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (s_cmd_accept !== 1'b1 || s_resp !== RESP_NULL || s_data !== '0) begin
      errors++;
      $display("FAIL post_reset got cmd_accept=%b resp=%0d data=%h required 1,0,0",
               s_cmd_accept, s_resp, s_data);
    end
  endtask

  task automatic test_wrnp_read();
    exp_q.push_back(pack_resp(RESP_DVA, 1'b1, 5'd5, '0));
    send_req(CMD_WRNP, 5'd3, 4'd1, SEQ_INCR, 5'd5);
    send_beat(32'hDEADBEEF, 4'hF, 1'b1);
    sb_collect(1'b0, "wrnp_resp");
    exp_q.push_back(pack_resp(RESP_DVA, 1'b1, 5'd9, 32'hDEADBEEF));
    send_req(CMD_RD, 5'd3, 4'd1, SEQ_INCR, 5'd9);
    sb_collect(1'b0, "rd_after_wrnp");
  endtask

  task automatic test_incr_wrap();
    send_req(CMD_WR, 5'd30, 4'd4, SEQ_INCR, 5'd3);
    for (int i = 0; i < 4; i++) send_beat(DW'(i + 1), 4'hF, (i == 3));
    checks++;
    if (s_cmd_accept !== 1'b1 || s_resp !== RESP_NULL) begin
      errors++;
      $display("FAIL wr_no_resp got cmd_accept=%b resp=%0d required 1,0", s_cmd_accept, s_resp);
    end
    for (int i = 0; i < 4; i++) exp_q.push_back(pack_resp(RESP_DVA, (i == 3), 5'd7, DW'(i + 1)));
    send_req(CMD_RD, 5'd30, 4'd4, SEQ_INCR, 5'd7);
    for (int i = 0; i < 4; i++) sb_collect((i % 2) == 1, $sformatf("incr_rd_beat%0d", i));
    // burst_length 0 behaves as a single beat; address 31 holds 2
    exp_q.push_back(pack_resp(RESP_DVA, 1'b1, 5'd8, 32'd2));
    send_req(CMD_RD, 5'd31, 4'd0, SEQ_INCR, 5'd8);
    sb_collect(1'b0, "len0_rd");
    checks++;
    if (s_cmd_accept !== 1'b1) begin
      errors++;
      $display("FAIL len0_back_to_idle got %b required 1", s_cmd_accept);
    end
  endtask

  task automatic test_err_cmds();
    exp_q.push_back(pack_resp(RESP_ERR, 1'b1, 5'd4, '0));
    send_req(CMD_RD, 5'd30, 4'd4, SEQ_WRAP, 5'd4);
    sb_collect(1'b0, "wrap_rd_err");
    checks++;
    if (s_cmd_accept !== 1'b1 || s_resp !== RESP_NULL) begin
      errors++;
      $display("FAIL wrap_err_single_beat got cmd_accept=%b resp=%0d required 1,0",
               s_cmd_accept, s_resp);
    end
    exp_q.push_back(pack_resp(RESP_ERR, 1'b1, 5'd6, '0));
    send_req(CMD_RDEX, 5'd3, 4'd1, SEQ_INCR, 5'd6);
    sb_collect(1'b1, "rdex_err");
  endtask

  task automatic test_last_err();
    exp_q.push_back(pack_resp(RESP_ERR, 1'b1, 5'd11, '0));
    send_req(CMD_WRNP, 5'd10, 4'd2, SEQ_INCR, 5'd11);
    send_beat(32'h0000_000A, 4'hF, 1'b1);
    send_beat(32'h0000_000B, 4'hF, 1'b0);
    sb_collect(1'b0, "last_err_resp");
    exp_q.push_back(pack_resp(RESP_DVA, 1'b0, 5'd12, 32'h0000_000A));
    exp_q.push_back(pack_resp(RESP_DVA, 1'b1, 5'd12, 32'h0000_000B));
    send_req(CMD_RD, 5'd10, 4'd2, SEQ_INCR, 5'd12);
    sb_collect(1'b0, "last_err_rd0");
    sb_collect(1'b0, "last_err_rd1");
  endtask

  task automatic test_byteen();
    logic [DW-1:0] exp_word;
    send_req(CMD_WR, 5'd20, 4'd1, SEQ_INCR, 5'd1);
    send_beat(32'h0, 4'hF, 1'b1);
    send_req(CMD_WR, 5'd20, 4'd1, SEQ_INCR, 5'd1);
    send_beat(32'hAABBCCDD, 4'b0101, 1'b1);
`ifdef OCP_SRAM_BYTEEN_EN
    exp_word = 32'h00BB00DD;
`else
    exp_word = 32'hAABBCCDD;
`endif
    exp_q.push_back(pack_resp(RESP_DVA, 1'b1, 5'd2, exp_word));
    send_req(CMD_RD, 5'd20, 4'd1, SEQ_INCR, 5'd2);
    sb_collect(1'b0, "byteen_rd");
    // a beat with no byte enables modifies nothing when masking is on
    send_req(CMD_WR, 5'd20, 4'd1, SEQ_INCR, 5'd1);
    send_beat(32'h12345678, 4'b0000, 1'b1);
`ifndef OCP_SRAM_BYTEEN_EN
    exp_word = 32'h12345678;
`endif
    exp_q.push_back(pack_resp(RESP_DVA, 1'b1, 5'd3, exp_word));
    send_req(CMD_RD, 5'd20, 4'd1, SEQ_INCR, 5'd3);
    sb_collect(1'b0, "byteen0_rd");
  endtask

  task automatic test_reset_mid_burst();
    int n;
    send_req(CMD_WR, 5'd12, 4'd2, SEQ_INCR, 5'd0);
    send_beat(32'hA0, 4'hF, 1'b0);
    send_beat(32'hA1, 4'hF, 1'b1);
    send_req(CMD_WR, 5'd12, 4'd4, SEQ_INCR, 5'd0);
    send_beat(32'h11, 4'hF, 1'b0);
    // reset arrives together with the second beat, which must be dropped
    rst = 1'b1;
    m_data = 32'h22;
    m_data_byteen = 4'hF;
    m_data_valid = 1'b1;
    @(posedge clk); #1;
    m_data_valid = 1'b0;
    checks++;
    if (s_data_accept !== 1'b0 || s_cmd_accept !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_outputs got daccept=%b cmd_accept=%b required 0,0",
               s_data_accept, s_cmd_accept);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (s_cmd_accept !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset_idle got %b required 1", s_cmd_accept);
    end
    n = $urandom_range(0, 3);
    repeat (n) begin @(posedge clk); #1; end
    exp_q.push_back(pack_resp(RESP_DVA, 1'b0, 5'd1, 32'h11));
    exp_q.push_back(pack_resp(RESP_DVA, 1'b1, 5'd1, 32'hA1));
    send_req(CMD_RD, 5'd12, 4'd2, SEQ_INCR, 5'd1);
    sb_collect(1'b0, "mid_reset_rd0");
    sb_collect(1'b1, "mid_reset_rd1");
  endtask

  initial begin
    rst = 1'b1;
    m_cmd = CMD_IDLE;
    m_addr = '0;
    m_burst_length = '0;
    m_burst_seq = SEQ_INCR;
    m_tagid = '0;
    m_data = '0;
    m_data_byteen = '0;
    m_data_valid = 1'b0;
    m_data_last = 1'b0;
    m_resp_accept = 1'b0;
    test_reset();
    test_wrnp_read();
    test_incr_wrap();
    test_err_cmds();
    test_last_err();
    test_byteen();
    test_reset_mid_burst();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d beats left required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // overall time bound so the run always ends
  initial begin
    #200000;
    $display("FAIL global_timeout got no completion required finish before 200000");
    $fatal(1);
  end

endmodule
